// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Bundles the CPU, host and data-memory signals of the data-memory
//            arbiter. The slave view is the arbiter; the master view is the
//            environment (CPU MEM stage, host port and data_memory).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_lock;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    logic              locked;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        output host_gnt, host_rdata, host_rvalid,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output locked
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        input  host_gnt, host_rdata, host_rvalid,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  locked
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data memory between the CPU MEM stage and
//            a host port. CPU has fixed priority, the host is guaranteed a
//            grant after STARVE_LIMIT denied cycles, and the host can hold the
//            memory atomically with host_lock.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           pc_reset,
    dmem_arbiter_if.slave  bus
);
    localparam logic [0:0] c_ARB    = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [3:0]        r_starve_cnt;
    logic              r_rd_pending;
    logic              r_rd_owner;      // 1 = host, 0 = CPU
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_cpu_gnt;
    logic              w_host_gnt;
    logic              w_cpu_rvalid;
    logic              w_host_rvalid;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_read;
    logic              w_mem_write;

    // Per-cycle grant decision; nothing is granted while reset is held.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_host_gnt = 1'b0;
        if (!pc_reset) begin
            if (r_state == c_LOCKED) begin
                w_host_gnt = bus.host_req;
            end else if (bus.host_req && (r_starve_cnt == c_STARVE_LIMIT)) begin
                w_host_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (bus.host_req) begin
                w_host_gnt = 1'b1;
            end
        end
    end

    // Lock entry on a locked host grant; leave on the first cycle lock drops.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ARB:    if (w_host_gnt && bus.host_lock) w_state_nxt = c_LOCKED;
            c_LOCKED: if (!bus.host_lock)              w_state_nxt = c_ARB;
            default:  w_state_nxt = c_ARB;
        endcase
    end

    // Memory command muxed from whichever requester holds the grant.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        if (w_cpu_gnt) begin
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
            w_mem_read  = ~bus.cpu_we;
            w_mem_write = bus.cpu_we;
        end else if (w_host_gnt) begin
            w_mem_addr  = bus.host_addr;
            w_mem_wdata = bus.host_wdata;
            w_mem_read  = ~bus.host_we;
            w_mem_write = bus.host_we;
        end
    end

    // A read return in progress during reset is dropped rather than delivered.
    assign w_cpu_rvalid  = r_rd_pending & ~r_rd_owner & ~pc_reset;
    assign w_host_rvalid = r_rd_pending &  r_rd_owner & ~pc_reset;

    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.cpu_stall   = bus.cpu_req & ~w_cpu_gnt & ~pc_reset;
    assign bus.host_gnt    = w_host_gnt;
    assign bus.cpu_rvalid  = w_cpu_rvalid;
    assign bus.host_rvalid = w_host_rvalid;
    assign bus.cpu_rdata   = w_cpu_rvalid  ? bus.mem_rdata : r_cpu_rdata;
    assign bus.host_rdata  = w_host_rvalid ? bus.mem_rdata : r_host_rdata;
    assign bus.locked      = (r_state == c_LOCKED);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (pc_reset) r_state <= c_ARB;
        else          r_state <= w_state_nxt;
    end

    // Host starvation counter: counts denied requesting cycles, saturating.
    always_ff @(posedge clk) begin
        if (pc_reset || w_host_gnt || !bus.host_req) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Read tag: which requester owns the data memory returns next cycle.
    always_ff @(posedge clk) begin
        if (pc_reset) begin
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_rd_pending <= w_mem_read;
            r_rd_owner   <= w_host_gnt;
        end
    end

    // Hold each requester's last returned data while the other one reads.
    always_ff @(posedge clk) begin
        if (pc_reset) begin
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            if (w_cpu_rvalid)  r_cpu_rdata  <= bus.mem_rdata;
            if (w_host_rvalid) r_host_rdata <= bus.mem_rdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: vector table plus
//            hand-written starvation and reset-during-lock sequences, with a
//            read-return scoreboard backed by a reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic pc_reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .pc_reset (pc_reset),
        .bus      (bus)
    );

    // Data memory: write commits at the grant edge, read data one cycle later.
    logic [15:0] mem [256];
    logic [15:0] mem_q;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_read)  mem_q <= mem[bus.mem_addr[7:0]];
    end
    assign bus.mem_rdata = mem_q;

    typedef struct {
        logic        rst;
        logic        c_req, c_we;
        logic [15:0] c_addr, c_wd;
        logic        h_req, h_we;
        logic [15:0] h_addr, h_wd;
        logic        h_lock;
        logic        e_stall, e_hgnt, e_locked;
    } vec_t;

    typedef struct {
        bit          host;
        logic [15:0] data;
        int          due;
    } rd_t;

    rd_t         sb_q[$];
    logic [15:0] ref_mem [256];
    logic [15:0] last_cpu, last_host;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    vec_t        tbl [20];

    function automatic vec_t mk(logic rst, logic creq, logic cwe, logic [15:0] caddr,
                                logic [15:0] cwd, logic hreq, logic hwe, logic [15:0] haddr,
                                logic [15:0] hwd, logic hlock, logic es, logic eh, logic el);
        vec_t v;
        v.rst = rst; v.c_req = creq; v.c_we = cwe; v.c_addr = caddr; v.c_wd = cwd;
        v.h_req = hreq; v.h_we = hwe; v.h_addr = haddr; v.h_wd = hwd; v.h_lock = hlock;
        v.e_stall = es; v.e_hgnt = eh; v.e_locked = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle, check the combinational response and the read return.
    task automatic apply(input vec_t v);
        logic        e_cgnt, er, ew;
        logic [15:0] ea, ed;
        rd_t         it;
        pc_reset       = v.rst;
        bus.cpu_req    = v.c_req;  bus.cpu_we  = v.c_we;
        bus.cpu_addr   = v.c_addr; bus.cpu_wdata = v.c_wd;
        bus.host_req   = v.h_req;  bus.host_we = v.h_we;
        bus.host_addr  = v.h_addr; bus.host_wdata = v.h_wd;
        bus.host_lock  = v.h_lock;
        @(negedge clk);
        cyc++;
        e_cgnt = v.c_req && !v.e_stall && !v.rst && !v.e_hgnt;
        er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        if (e_cgnt) begin
            er = ~v.c_we; ew = v.c_we; ea = v.c_addr; ed = v.c_wd;
        end else if (v.e_hgnt) begin
            er = ~v.h_we; ew = v.h_we; ea = v.h_addr; ed = v.h_wd;
        end
        chk("cpu_stall", 16'(bus.cpu_stall), 16'(v.e_stall));
        chk("host_gnt",  16'(bus.host_gnt),  16'(v.e_hgnt));
        chk("mem_read",  16'(bus.mem_read),  16'(er));
        chk("mem_write", 16'(bus.mem_write), 16'(ew));
        chk("mem_addr",  bus.mem_addr,  ea);
        chk("mem_wdata", bus.mem_wdata, ed);
        chk("locked",    16'(bus.locked),    16'(v.e_locked));
        if (v.rst) begin
            chk("cpu_rvalid_rst",  16'(bus.cpu_rvalid),  16'd0);
            chk("host_rvalid_rst", 16'(bus.host_rvalid), 16'd0);
            sb_q.delete();
            last_cpu = '0; last_host = '0;
        end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            it = sb_q.pop_front();
            if (it.host) begin
                chk("host_rvalid", 16'(bus.host_rvalid), 16'd1);
                chk("cpu_rvalid",  16'(bus.cpu_rvalid),  16'd0);
                chk("host_rdata",  bus.host_rdata, it.data);
                chk("cpu_rdata_hold", bus.cpu_rdata, last_cpu);
                last_host = it.data;
            end else begin
                chk("cpu_rvalid",  16'(bus.cpu_rvalid),  16'd1);
                chk("host_rvalid", 16'(bus.host_rvalid), 16'd0);
                chk("cpu_rdata",   bus.cpu_rdata, it.data);
                chk("host_rdata_hold", bus.host_rdata, last_host);
                last_cpu = it.data;
            end
        end else begin
            chk("cpu_rvalid_idle",  16'(bus.cpu_rvalid),  16'd0);
            chk("host_rvalid_idle", 16'(bus.host_rvalid), 16'd0);
            chk("cpu_rdata_hold",   bus.cpu_rdata,  last_cpu);
            chk("host_rdata_hold",  bus.host_rdata, last_host);
        end
        if (!v.rst && er) begin
            it.host = v.e_hgnt; it.data = ref_mem[ea[7:0]]; it.due = cyc + 1;
            sb_q.push_back(it);
        end
        if (!v.rst && ew) ref_mem[ea[7:0]] = ed;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [3:0] cnt;
        logic       hwin;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0000; ref_mem[i] = 16'h0000;
        end
        mem[8'h20] = 16'hAAAA; ref_mem[8'h20] = 16'hAAAA;
        mem[8'h21] = 16'h5555; ref_mem[8'h21] = 16'h5555;
        last_cpu = '0; last_host = '0;

        //            rst creq cwe caddr    cwd      hreq hwe haddr    hwd      lock stl hg lk
        tbl[0]  = mk(0, 1, 1, 16'h0010, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0021, 16'h0000, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0030, 16'hBEEF, 0, 0, 1, 0);
        tbl[7]  = mk(0, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0021, 16'h0000, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0021, 16'h0000, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0021, 16'h0000, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'h1111, 1, 0, 1, 0);
        tbl[14] = mk(0, 1, 1, 16'h0050, 16'h5555, 1, 1, 16'h0041, 16'h2222, 1, 1, 1, 1);
        tbl[15] = mk(0, 1, 1, 16'h0050, 16'h5555, 1, 1, 16'h0042, 16'h3333, 1, 1, 1, 1);
        tbl[16] = mk(0, 1, 1, 16'h0050, 16'h5555, 1, 1, 16'h0043, 16'h4444, 0, 1, 1, 1);
        tbl[17] = mk(0, 1, 1, 16'h0050, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 16'h0042, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

        // Power-up reset with idle inputs.
        pc_reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.host_lock = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_starve_cnt", 16'(dut.r_starve_cnt), 16'd0);

        // Reset values are covered by the first idle-checked vector.
        apply(mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) apply(tbl[i]);

        // Starvation: both request for 10 cycles, host wins whenever count hits 4.
        cnt = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            chk("starve_cnt", 16'(dut.r_starve_cnt), 16'(cnt));
            hwin = (cnt == 4'd4);
            apply(mk(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0021, 16'h0, 0, hwin, hwin, 0));
            cnt = hwin ? 4'd0 : ((cnt < 4'd4) ? cnt + 4'd1 : cnt);
        end
        apply(mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0));

        // Reset in LOCKED with a host read pending: return is dropped.
        apply(mk(0, 0, 0, 16'h0000, 16'h0, 1, 0, 16'h0021, 16'h0, 1, 0, 1, 0));
        apply(mk(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 1, 1, 1, 1));
        // Registers still show LOCKED until the reset edge.
        apply(mk(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, 1, 0, 0, 1));
        chk("post_reset_starve_cnt", 16'(dut.r_starve_cnt), 16'd0);
        apply(mk(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0021, 16'h0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0));

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
